// File: rtl/inertial_sensor_reader_if.sv
// Signal bundle between the inertial sensor reader, the SPI transactor below it
// and the pitch integrator above it.
interface inertial_sensor_reader_if;
   logic        INT;
   logic        spi_done;
   logic [15:0] spi_rd_data;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        vld;
   logic [15:0] ptch_rt;
   logic [15:0] AZ;

   modport master (
      input  INT, spi_done, spi_rd_data,
      output spi_wrt, spi_cmd, vld, ptch_rt, AZ
   );

   modport slave (
      output INT, spi_done, spi_rd_data,
      input  spi_wrt, spi_cmd, vld, ptch_rt, AZ
   );
endinterface

// File: rtl/inertial_sensor_reader.sv
// Configures the IMU after reset, then reads pitch rate and Z acceleration on each
// data-ready interrupt and presents both samples together with a one-cycle vld.
module inertial_sensor_reader #(
   parameter int INIT_WAIT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   inertial_sensor_reader_if.master  bus
);

   typedef enum logic [3:0] {
      S_WAIT, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_IDLE,
      S_RD_PL, S_RD_PH, S_RD_AL, S_RD_AH, S_VLD
   } state_t;

   localparam logic [INIT_WAIT_W-1:0] CNT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

   state_t                 r_state;
   logic [INIT_WAIT_W-1:0] r_cnt;
   logic                   r_int_s1, r_int_s2, r_int_s3;
   logic [7:0]             r_pl, r_ph, r_al;
   logic                   r_spi_wrt, r_vld;
   logic [15:0]            r_spi_cmd, r_ptch_rt, r_az;
   logic                   w_int_rise;
   state_t                 w_next;
   logic                   w_unused;

   function automatic logic [15:0] f_cmd(input state_t s);
      case (s)
         S_INIT1: f_cmd = 16'h0D02;
         S_INIT2: f_cmd = 16'h1053;
         S_INIT3: f_cmd = 16'h1150;
         S_INIT4: f_cmd = 16'h1460;
         S_RD_PL: f_cmd = 16'hA200;
         S_RD_PH: f_cmd = 16'hA300;
         S_RD_AL: f_cmd = 16'hAC00;
         S_RD_AH: f_cmd = 16'hAD00;
         default: f_cmd = 16'h0000;
      endcase
   endfunction

   function automatic state_t f_next(input state_t s);
      case (s)
         S_INIT1: f_next = S_INIT2;
         S_INIT2: f_next = S_INIT3;
         S_INIT3: f_next = S_INIT4;
         S_INIT4: f_next = S_IDLE;
         S_RD_PL: f_next = S_RD_PH;
         S_RD_PH: f_next = S_RD_AL;
         S_RD_AL: f_next = S_RD_AH;
         S_RD_AH: f_next = S_VLD;
         default: f_next = S_WAIT;
      endcase
   endfunction

   function automatic logic f_is_cmd(input state_t s);
      case (s)
         S_INIT1, S_INIT2, S_INIT3, S_INIT4,
         S_RD_PL, S_RD_PH, S_RD_AL, S_RD_AH: f_is_cmd = 1'b1;
         default:                            f_is_cmd = 1'b0;
      endcase
   endfunction

   assign w_int_rise = r_int_s2 & ~r_int_s3;
   assign w_next     = f_next(r_state);
   assign w_unused   = ^bus.spi_rd_data[15:8];

   // Sequencer: command states raise spi_wrt on entry and advance on spi_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_WAIT;
         r_cnt     <= '0;
         r_int_s1  <= 1'b0;
         r_int_s2  <= 1'b0;
         r_int_s3  <= 1'b0;
         r_pl      <= 8'h00;
         r_ph      <= 8'h00;
         r_al      <= 8'h00;
         r_spi_wrt <= 1'b0;
         r_spi_cmd <= 16'h0000;
         r_vld     <= 1'b0;
         r_ptch_rt <= 16'h0000;
         r_az      <= 16'h0000;
      end else begin
         r_int_s1  <= bus.INT;
         r_int_s2  <= r_int_s1;
         r_int_s3  <= r_int_s2;
         r_spi_wrt <= 1'b0;
         r_vld     <= 1'b0;
         case (r_state)
            S_WAIT: begin
               if (&r_cnt) begin
                  r_state   <= S_INIT1;
                  r_spi_wrt <= 1'b1;
                  r_spi_cmd <= f_cmd(S_INIT1);
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_IDLE: begin
               if (w_int_rise) begin
                  r_state   <= S_RD_PL;
                  r_spi_wrt <= 1'b1;
                  r_spi_cmd <= f_cmd(S_RD_PL);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_VLD: begin
               r_state <= S_IDLE;
            end
            S_INIT1, S_INIT2, S_INIT3, S_INIT4,
            S_RD_PL, S_RD_PH, S_RD_AL, S_RD_AH: begin
               if (bus.spi_done) begin
                  r_state <= w_next;
                  if (f_is_cmd(w_next)) begin
                     r_spi_wrt <= 1'b1;
                     r_spi_cmd <= f_cmd(w_next);
                  end else begin
                     r_spi_wrt <= 1'b0;
                  end
                  case (r_state)
                     S_RD_PL: r_pl <= bus.spi_rd_data[7:0];
                     S_RD_PH: r_ph <= bus.spi_rd_data[7:0];
                     S_RD_AL: r_al <= bus.spi_rd_data[7:0];
                     default: r_pl <= r_pl;
                  endcase
                  // The AZ high byte goes straight to the output so vld lands one cycle after the last read.
                  if (r_state == S_RD_AH) begin
                     r_vld     <= 1'b1;
                     r_ptch_rt <= {r_ph, r_pl};
                     r_az      <= {bus.spi_rd_data[7:0], r_al};
                  end else begin
                     r_vld <= 1'b0;
                  end
               end else begin
                  r_state <= r_state;
               end
            end
            default: begin
               r_state <= S_WAIT;
            end
         endcase
      end
   end

   assign bus.spi_wrt = r_spi_wrt;
   assign bus.spi_cmd = r_spi_cmd;
   assign bus.vld     = r_vld;
   assign bus.ptch_rt = r_ptch_rt;
   assign bus.AZ      = r_az;

endmodule

// File: tb/tb_inertial_sensor_reader.sv
// Scoreboard bench for inertial_sensor_reader: an SPI register model answers reads,
// expected commands and samples are queued by the stimulus and checked by a monitor.
module tb_inertial_sensor_reader;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inertial_sensor_reader_if bus();
   inertial_sensor_reader #(.INIT_WAIT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] exp_cmd_q[$];
   logic [31:0] exp_out_q[$];

   // SPI / IMU register model controls
   logic [7:0]  rd_bytes [4];
   logic        noise_en = 1'b0;
   int          spi_lat = 20;
   int          spur_req = 0;
   int          spur_done = 0;
   logic        pending = 1'b0;
   logic [15:0] pend_cmd = 16'h0000;
   int          lat_cnt = 0;
   int          last_done_cyc = -10;
   int          vld_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // IMU register file seen through the transactor: byte for each read address
   function automatic logic [7:0] resp(input logic [15:0] cmd);
      case (cmd)
         16'hA200: resp = rd_bytes[0];
         16'hA300: resp = rd_bytes[1];
         16'hAC00: resp = rd_bytes[2];
         16'hAD00: resp = rd_bytes[3];
         default:  resp = 8'h00;
      endcase
   endfunction

   // SPI transactor model: spi_done spi_lat cycles after each spi_wrt
   initial begin
      bus.spi_done    = 1'b0;
      bus.spi_rd_data = 16'h0000;
      forever begin
         @(negedge clk);
         bus.spi_done = 1'b0;
         if (rst) begin
            pending = 1'b0;
         end else if (pending) begin
            if (lat_cnt <= 1) begin
               bus.spi_rd_data = {(noise_en ? 8'($urandom) : 8'h00), resp(pend_cmd)};
               bus.spi_done    = 1'b1;
               pending         = 1'b0;
               last_done_cyc   = cyc;
            end else begin
               lat_cnt--;
            end
         end else if (bus.spi_wrt === 1'b1) begin
            pending  = 1'b1;
            pend_cmd = bus.spi_cmd;
            lat_cnt  = spi_lat;
         end else if (spur_req != spur_done) begin
            bus.spi_done    = 1'b1;
            bus.spi_rd_data = 16'hA5A5;
            spur_done++;
         end
      end
   end

   // Monitor: pops expected commands and samples whenever the DUT presents them
   initial begin
      logic        rst_q, wrt_q, first_after_rst;
      int          since_rst;
      logic [15:0] cur_cmd, held_p, held_a, ec;
      logic [31:0] eo;
      rst_q = 1'b1; wrt_q = 1'b0; first_after_rst = 1'b1; since_rst = 0;
      cur_cmd = 16'h0000; held_p = 16'h0000; held_a = 16'h0000;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst_q) begin
            cur_cmd = 16'h0000; held_p = 16'h0000; held_a = 16'h0000; wrt_q = 1'b0;
         end
         if (bus.spi_wrt === 1'b1) begin
            chk("wrt_one_cycle", {31'd0, wrt_q}, 32'd0);
            if (first_after_rst) begin
               chk("settle_cycles", since_rst, 2 ** W);
               first_after_rst = 1'b0;
            end
            if (exp_cmd_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_wrt: got cmd 0x%0h, expected no transaction (cycle %0d)", bus.spi_cmd, cyc);
            end else begin
               ec = exp_cmd_q.pop_front();
               chk("spi_cmd", {16'h0, bus.spi_cmd}, {16'h0, ec});
               cur_cmd = ec;
            end
         end else begin
            chk("spi_cmd_hold", {16'h0, bus.spi_cmd}, {16'h0, cur_cmd});
         end
         if (bus.vld === 1'b1) begin
            chk("vld_after_done", cyc, last_done_cyc + 1);
            if (exp_out_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_vld: got ptch_rt 0x%0h AZ 0x%0h, expected no vld (cycle %0d)", bus.ptch_rt, bus.AZ, cyc);
            end else begin
               eo = exp_out_q.pop_front();
               chk("ptch_rt", {16'h0, bus.ptch_rt}, {16'h0, eo[31:16]});
               chk("AZ", {16'h0, bus.AZ}, {16'h0, eo[15:0]});
               held_p = eo[31:16];
               held_a = eo[15:0];
            end
            vld_count++;
         end else begin
            chk("out_hold", {bus.ptch_rt, bus.AZ}, {held_p, held_a});
         end
         wrt_q = bus.spi_wrt;
         rst_q = rst;
         if (rst) begin
            since_rst = 0; first_after_rst = 1'b1;
         end else begin
            since_rst++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_init();
      exp_cmd_q.push_back(16'h0D02);
      exp_cmd_q.push_back(16'h1053);
      exp_cmd_q.push_back(16'h1150);
      exp_cmd_q.push_back(16'h1460);
   endtask

   task automatic push_sample(input logic [7:0] b0, b1, b2, b3);
      rd_bytes[0] = b0; rd_bytes[1] = b1; rd_bytes[2] = b2; rd_bytes[3] = b3;
      exp_cmd_q.push_back(16'hA200);
      exp_cmd_q.push_back(16'hA300);
      exp_cmd_q.push_back(16'hAC00);
      exp_cmd_q.push_back(16'hAD00);
      exp_out_q.push_back({b1, b0, b3, b2});
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int t;
      t = 0;
      while ((exp_cmd_q.size() != 0 || exp_out_q.size() != 0 || pending) && t < budget) begin
         tick(1);
         t++;
      end
      checks++;
      if (t >= budget) begin
         fails++;
         $display("FAIL %s: timeout after %0d cycles, %0d cmds and %0d samples outstanding, expected none",
                  name, t, exp_cmd_q.size(), exp_out_q.size());
         exp_cmd_q.delete();
         exp_out_q.delete();
      end
      tick(4);
   endtask

   task automatic wait_cmd(input string name, input logic [15:0] cmd);
      int t;
      t = 0;
      while (!(pending && pend_cmd == cmd) && t < 500) begin
         tick(1);
         t++;
      end
      checks++;
      if (t >= 500) begin
         fails++;
         $display("FAIL %s: command 0x%0h not seen within %0d cycles", name, cmd, t);
      end
   endtask

   task automatic do_read(input string name, input logic [7:0] b0, b1, b2, b3);
      push_sample(b0, b1, b2, b3);
      bus.INT = 1'b1;
      wait_quiet(name, 2000);
      bus.INT = 1'b0;
      tick(4);
   endtask

   initial begin
      int vc;
      bus.INT = 1'b0;
      rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
      push_init();
      tick(2);
      chk("rst_vld", {31'd0, bus.vld}, 32'd0);
      chk("rst_wrt", {31'd0, bus.spi_wrt}, 32'd0);
      chk("rst_cmd", {16'h0, bus.spi_cmd}, 32'd0);
      chk("rst_out", {bus.ptch_rt, bus.AZ}, 32'd0);
      rst = 1'b0;
      wait_quiet("init", 2000);

      do_read("read_basic", 8'h34, 8'h12, 8'h78, 8'h56);
      do_read("read_negative", 8'hB0, 8'hFF, 8'h60, 8'hFF);
      noise_en = 1'b1;
      do_read("read_masked", 8'h34, 8'h12, 8'h78, 8'h56);
      noise_en = 1'b0;

      // Interrupt re-pulsed mid-read: exactly one sample, no re-read while INT stays high
      vc = vld_count;
      push_sample(8'h11, 8'h22, 8'h33, 8'h44);
      bus.INT = 1'b1;
      wait_cmd("int_mid_ph", 16'hA300);
      bus.INT = 1'b0;
      tick(3);
      bus.INT = 1'b1;
      wait_quiet("int_mid_read", 2000);
      tick(60);
      chk("one_vld_per_int", vld_count - vc, 1);
      bus.INT = 1'b0;
      tick(4);
      do_read("read_after_reint", 8'hC3, 8'h7E, 8'h01, 8'h80);

      // Stray spi_done while idle must not move the sequencer
      spur_req++;
      tick(40);
      do_read("read_after_spurious", 8'h5A, 8'hA5, 8'hEE, 8'h0F);

      for (int i = 0; i < 8; i++) begin
         spi_lat  = $urandom_range(1, 20);
         noise_en = 1'($urandom);
         do_read("read_random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      noise_en = 1'b0;
      spi_lat  = 20;

      // Reset during RD_AL: outputs clear, init re-runs, no vld without a fresh INT
      vc = vld_count;
      push_sample(8'h9A, 8'hBC, 8'hDE, 8'hF0);
      bus.INT = 1'b1;
      wait_cmd("rst_mid_al", 16'hAC00);
      tick(3);
      exp_cmd_q.delete();
      exp_out_q.delete();
      push_init();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_vld", {31'd0, bus.vld}, 32'd0);
      chk("midrst_wrt", {31'd0, bus.spi_wrt}, 32'd0);
      chk("midrst_out", {bus.ptch_rt, bus.AZ}, 32'd0);
      wait_quiet("reinit", 2000);
      tick(50);
      chk("no_vld_after_rst", vld_count - vc, 0);
      bus.INT = 1'b0;
      tick(4);
      do_read("read_after_rst", 8'h34, 8'h12, 8'h78, 8'h56);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
